// File: rtl/tx_ctrl.sv
// rtl/tx_ctrl.sv - audio transmitter controller: sample FIFO, gain ramp FSM, retune sequencing
// Optional underflow statistics counter enabled by defining TX_CTRL_STATS_EN.
module tx_ctrl #(
  parameter int unsigned FCLK       = 200000000,
  parameter int unsigned FS_IN      = 48000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RAMP_LOG2  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        cfg_wr,
  input  logic        cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [15:0] data_out,
  output logic        stb_out,
  output logic        tx_rst,
  output logic [31:0] tune_word,
  output logic        tune_stb,
  output logic [1:0]  state
`ifdef TX_CTRL_STATS_EN
  ,
  output logic [15:0] underflow_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned GW = RAMP_LOG2 + 1;
  localparam int unsigned PW = 16 + GW + 1;
  localparam logic [63:0] INC_WIDE  = (64'(FS_IN) << 32) / 64'(FCLK);
  localparam logic [31:0] PHASE_INC = INC_WIDE[31:0];
  localparam logic [GW-1:0] GAIN_MAX = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_ON        = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  gain_q, gain_d;
  logic [31:0]    acc_q, acc_d;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [15:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [31:0]    tune_word_q, tune_word_d;
  logic [31:0]    pend_word_q, pend_word_d;
  logic           pend_q, pend_d;
  logic [15:0]    data_out_q, data_out_d;
  logic           stb_q, stb_d;
  logic           tune_stb_q, tune_stb_d;
  logic           rdy_q;

  logic           tick, empty, full, enable, mute;
  logic           pop_slot, do_pop, do_push, underflow;
  logic [15:0]    sample;
  logic [PW-1:0]  sample_ext, gain_ext, prod;

  assign enable = ctrl_q[0];
  assign mute   = ctrl_q[1];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign s_ready = rdy_q & ~full;

  // Occupancy is taken from the current pointers, so a same-cycle write cannot feed this tick.
  assign pop_slot  = tick && (state_q != S_IDLE);
  assign do_pop    = pop_slot && !empty;
  assign underflow = pop_slot && empty;
  assign do_push   = s_valid && s_ready;

  always_comb begin
    {tick, acc_d} = {1'b0, acc_q} + {1'b0, PHASE_INC};

    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q[AW-1:0]] = s_data;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    sample   = do_pop ? mem_q[rd_ptr_q[AW-1:0]] : 16'd0;

    gain_d = gain_q;
    if (tick) begin
      if (state_q == S_RAMP_UP && gain_q != GAIN_MAX) gain_d = gain_q + GW'(1);
      if (state_q == S_RAMP_DOWN && gain_q != '0)     gain_d = gain_q - GW'(1);
    end

    // Sign-extended operands make the low PW bits of the unsigned product the signed result.
    sample_ext = {{(PW-16){sample[15]}}, sample};
    gain_ext   = {{(PW-GW){1'b0}}, gain_d};
    prod       = sample_ext * gain_ext;

    data_out_d = data_out_q;
    stb_d      = pop_slot;
    if (pop_slot) data_out_d = mute ? 16'd0 : 16'(prod >> RAMP_LOG2);
  end

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    tune_word_d = tune_word_q;
    tune_stb_d  = 1'b0;
    pend_d      = pend_q;
    pend_word_d = pend_word_q;

    case (state_q)
      S_IDLE:    if (enable) state_d = S_RAMP_UP;
      S_RAMP_UP: begin
        if (!enable || pend_q)     state_d = S_RAMP_DOWN;
        else if (gain_d == GAIN_MAX) state_d = S_ON;
      end
      S_ON:      if (!enable || pend_q) state_d = S_RAMP_DOWN;
      default: begin
        if (gain_d == '0) begin
          if (pend_q) begin
            tune_word_d = pend_word_q;
            tune_stb_d  = 1'b1;
            pend_d      = 1'b0;
          end
          state_d = enable ? S_RAMP_UP : S_IDLE;
        end
      end
    endcase

    // Config write is applied after the retune commit so a newer pending word wins.
    if (cfg_wr) begin
      if (!cfg_addr) begin
        ctrl_d = cfg_wdata[1:0];
      end else if (state_q == S_IDLE) begin
        tune_word_d = cfg_wdata;
        tune_stb_d  = 1'b1;
      end else begin
        pend_word_d = cfg_wdata;
        pend_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      gain_q      <= '0;
      acc_q       <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ctrl_q      <= '0;
      tune_word_q <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      data_out_q  <= '0;
      stb_q       <= 1'b0;
      tune_stb_q  <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      acc_q       <= acc_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ctrl_q      <= ctrl_d;
      tune_word_q <= tune_word_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      data_out_q  <= data_out_d;
      stb_q       <= stb_d;
      tune_stb_q  <= tune_stb_d;
      rdy_q       <= 1'b1;
    end
  end

  assign data_out  = data_out_q;
  assign stb_out   = stb_q;
  assign tune_word = tune_word_q;
  assign tune_stb  = tune_stb_q;
  assign state     = state_q;
  assign tx_rst    = (state_q == S_IDLE);

`ifdef TX_CTRL_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    if (cfg_wr && !cfg_addr && cfg_wdata[31]) ucnt_d = 16'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ucnt_q <= '0;
    else      ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`else
  logic unused_underflow;
  assign unused_underflow = underflow;
`endif

endmodule

// File: tb/tb_tx_ctrl.sv
// tb/tb_tx_ctrl.sv - scoreboard bench for tx_ctrl: prefill, ramp, mute, retune, disable, reset
module tb_tx_ctrl;

  localparam int M_IDLE = 0, M_UP = 1, M_HOLD = 2, M_DOWN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        cfg_wr;
  logic        cfg_addr;
  logic [31:0] cfg_wdata;
  logic [15:0] data_out;
  logic        stb_out;
  logic        tx_rst;
  logic [31:0] tune_word;
  logic        tune_stb;
  logic [1:0]  state;
`ifdef TX_CTRL_STATS_EN
  logic [15:0] underflow_cnt;
`endif

  tx_ctrl #(
    .FCLK(1000), .FS_IN(100), .FIFO_DEPTH(8), .RAMP_LOG2(8)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .data_out(data_out), .stb_out(stb_out), .tx_rst(tx_rst),
    .tune_word(tune_word), .tune_stb(tune_stb), .state(state)
`ifdef TX_CTRL_STATS_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [15:0] sb_q[$];
  int m_gain = 0, m_mode = M_IDLE, m_en = 0, m_mute = 0;
  int stb_cnt = 0, tune_stb_cnt = 0, txrst_seen = 0, watch_txrst = 0;
  int mon_s, mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (tune_stb) tune_stb_cnt++;
      if (watch_txrst != 0 && tx_rst) txrst_seen++;
      if (stb_out) begin
        stb_cnt++;
        mon_s = (sb_q.size() > 0) ? int'(sb_q.pop_front()) : 0;
        case (m_mode)
          M_UP: begin
            m_gain++;
            if (m_gain == 256) m_mode = M_HOLD;
          end
          M_DOWN: begin
            m_gain--;
            if (m_gain == 0) m_mode = (m_en != 0) ? M_UP : M_IDLE;
          end
          default: ;
        endcase
        mon_e = (m_mute != 0) ? 0 : ((mon_s * m_gain) >>> 8);
        check("data_out", {16'd0, data_out}, {16'd0, mon_e[15:0]});
      end
    end
  end

  task automatic wait_stb(input int n);
    int target;
    int budget;
    target = stb_cnt + n;
    budget = n * 12 + 40;
    while (stb_cnt < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (stb_cnt < target) check("stb_timeout", stb_cnt, target);
  endtask

  task automatic push(input logic [15:0] d);
    s_data  = d;
    s_valid = 1'b1;
    if (s_ready) sb_q.push_back(d);
    @(negedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic a, input logic [31:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    int s0;
    int ts0;
    logic [15:0] prefill [8];
    prefill = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h7FFF, 16'h8000, 16'hC000};
    rst = 1'b0; s_data = '0; s_valid = 1'b0; cfg_wr = 1'b0; cfg_addr = 1'b0; cfg_wdata = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_state", state, 0);
    check("rst_tx_rst", tx_rst, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_stb", stb_out, 0);
    check("rst_data", data_out, 0);
    check("rst_tune", tune_word, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_rel", s_ready, 1);

    for (int i = 0; i < 8; i++) push(prefill[i]);
    check("fifo_full", s_ready, 0);
    repeat (30) @(negedge clk);
    #1;
    check("idle_no_pop", stb_cnt, 0);

    m_en = 1; m_mode = M_UP;
    cfg_write(1'b0, 32'h1);
    check("txrst_before", tx_rst, 1);
    @(negedge clk);
    #1;
    check("txrst_fall", tx_rst, 0);
    check("state_up", state, 1);
    wait_stb(256);
    check("state_on", state, 2);

    push(16'h1234); push(16'hFEDC); push(16'h0001);
    wait_stb(3);
    m_mute = 1;
    cfg_write(1'b0, 32'h3);
    push(16'h5555);
    wait_stb(1);
    m_mute = 0;
    cfg_write(1'b0, 32'h1);

    wait_stb(1);
    ts0 = tune_stb_cnt;
    watch_txrst = 1; m_mode = M_DOWN;
    cfg_write(1'b1, 32'h12345678);
    push(16'h7FFF); push(16'h8000);
    wait_stb(256);
    check("retune_stb_cnt", tune_stb_cnt - ts0, 1);
    check("retune_word", tune_word, 32'h12345678);
    check("retune_state", state, 1);

    wait_stb(100);
    check("retune_txrst", txrst_seen, 0);
    watch_txrst = 0;
    m_en = 0; m_mode = M_DOWN;
    cfg_write(1'b0, 32'h0);
    wait_stb(100);
    check("off_state", state, 0);
    check("off_txrst", tx_rst, 1);
    s0 = stb_cnt;
    repeat (60) @(negedge clk);
    #1;
    check("off_no_stb", stb_cnt - s0, 0);

    cfg_write(1'b1, 32'hCAFEF00D);
    check("idle_tune_word", tune_word, 32'hCAFEF00D);
    check("idle_tune_stb", tune_stb, 1);
    @(negedge clk);
    #1;
    check("idle_tune_stb_end", tune_stb, 0);

    m_en = 1; m_mode = M_UP;
    cfg_write(1'b0, 32'h1);
    wait_stb(20);
    m_en = 0; m_mode = M_DOWN;
    cfg_write(1'b0, 32'h0);
    wait_stb(1);
    cfg_write(1'b1, 32'h0BADBEEF);
    wait_stb(1);
    for (int i = 0; i < 5; i++) push(16'h7FFF);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_txrst", tx_rst, 1);
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_stb", stb_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_tune", tune_word, 0);
    check("mid_rst_tune_stb", tune_stb, 0);
    sb_q.delete();
    m_gain = 0; m_mode = M_IDLE; m_en = 0; m_mute = 0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rel_ready", s_ready, 1);
    check("rel_state", state, 0);

    ts0 = tune_stb_cnt;
    m_en = 1; m_mode = M_UP;
    cfg_write(1'b0, 32'h1);
    wait_stb(3);
    check("no_stale_pending", state, 1);
    check("no_stale_tune", tune_stb_cnt - ts0, 0);
`ifdef TX_CTRL_STATS_EN
    check("underflow_cnt", underflow_cnt, 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
